// File: rtl/asm_inserter.sv
// asm_inserter: prepends the attached sync marker to each payload block, registered output slice.
// Build macro ASM_LEN_CHECK_EN enables the sticky payload length check on len_err.
module asm_inserter #(
    parameter logic [31:0] ASM_WORD    = 32'h1ACFFC1D,
    parameter int unsigned ASM_BYTES   = 4,
    parameter int unsigned BLOCK_BYTES = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_axis_valid,
    output logic       s_axis_ready,
    input  logic [7:0] s_axis_data,
    input  logic       s_axis_last,
    input  logic       s_axis_sop,
    input  logic       s_axis_is_parity,
    output logic       m_axis_valid,
    input  logic       m_axis_ready,
    output logic [7:0] m_axis_data,
    output logic       m_axis_last,
    output logic       m_axis_sop,
    output logic       m_axis_is_parity,
    output logic       len_err
);

    typedef enum logic {ST_ASM, ST_PAYLOAD} state_t;

    localparam logic [1:0] ASM_LAST = 2'(ASM_BYTES - 1);

    state_t     state;
    logic [1:0] asm_idx;
    logic       ld;
    logic       in_xfer;
    logic       unused_cfg;

    assign ld           = !m_axis_valid || m_axis_ready;
    assign s_axis_ready = (state == ST_PAYLOAD) && ld;
    assign in_xfer      = s_axis_valid && s_axis_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_ASM;
            asm_idx          <= '0;
            m_axis_valid     <= 1'b0;
            m_axis_data      <= '0;
            m_axis_last      <= 1'b0;
            m_axis_sop       <= 1'b0;
            m_axis_is_parity <= 1'b0;
        end else if (state == ST_ASM) begin
            // A started marker runs to completion regardless of s_axis_valid.
            if (ld && (s_axis_valid || asm_idx != '0)) begin
                m_axis_valid     <= 1'b1;
                m_axis_data      <= 8'(ASM_WORD >> {ASM_LAST - asm_idx, 3'b000});
                m_axis_sop       <= (asm_idx == '0);
                m_axis_last      <= 1'b0;
                m_axis_is_parity <= 1'b0;
                if (asm_idx == ASM_LAST) begin
                    asm_idx <= '0;
                    state   <= ST_PAYLOAD;
                end else begin
                    asm_idx <= asm_idx + 2'd1;
                end
            end else if (ld) begin
                m_axis_valid <= 1'b0;
            end
        end else begin
            if (in_xfer) begin
                m_axis_valid     <= 1'b1;
                m_axis_data      <= s_axis_data;
                m_axis_sop       <= 1'b0;
                m_axis_last      <= s_axis_last;
                m_axis_is_parity <= s_axis_is_parity;
                if (s_axis_last) begin
                    state <= ST_ASM;
                end
            end else if (ld) begin
                m_axis_valid <= 1'b0;
            end
        end
    end

`ifdef ASM_LEN_CHECK_EN
    localparam logic [9:0] CNT_END = 10'(BLOCK_BYTES - 1);

    logic [9:0] pay_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_cnt <= '0;
            len_err <= 1'b0;
        end else if (in_xfer) begin
            // Error when last and the final expected byte disagree, in either direction.
            if (s_axis_last != (pay_cnt == CNT_END)) begin
                len_err <= 1'b1;
            end
            pay_cnt <= s_axis_last ? '0 : pay_cnt + 10'd1;
        end
    end

    assign unused_cfg = s_axis_sop;
`else
    assign len_err    = 1'b0;
    assign unused_cfg = s_axis_sop | (BLOCK_BYTES == 0);
`endif

endmodule

// File: tb/tb_asm_inserter.sv
// Self-checking bench for asm_inserter: directed vector table plus randomized streams vs a framing model.
`timescale 1ns/1ps
module tb_asm_inserter;

    localparam logic [31:0] ASM   = 32'h1ACFFC1D;
    localparam int          BLOCK = 512;
    localparam int          LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_axis_valid = 1'b0;
    logic       s_axis_ready;
    logic [7:0] s_axis_data = '0;
    logic       s_axis_last = 1'b0;
    logic       s_axis_sop = 1'b0;
    logic       s_axis_is_parity = 1'b0;
    logic       m_axis_valid;
    logic       m_axis_ready = 1'b0;
    logic [7:0] m_axis_data;
    logic       m_axis_last;
    logic       m_axis_sop;
    logic       m_axis_is_parity;
    logic       len_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    asm_inserter #(
        .ASM_WORD   (32'h1ACFFC1D),
        .ASM_BYTES  (4),
        .BLOCK_BYTES(512)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .s_axis_last     (s_axis_last),
        .s_axis_sop      (s_axis_sop),
        .s_axis_is_parity(s_axis_is_parity),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .m_axis_last     (m_axis_last),
        .m_axis_sop      (m_axis_sop),
        .m_axis_is_parity(m_axis_is_parity),
        .len_err         (len_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       sp;
        logic       mr;
        logic       e_sr;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_sop;
        logic       e_last;
        logic       e_par;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       last;
        logic       par;
    } obyte_t;

    typedef struct packed {
        logic [7:0] d;
        logic       first;
        logic       last;
        logic       par;
    } ibyte_t;

    obyte_t exp_q[$];
    ibyte_t in_q[$];
    int     blk_len[$];
    logic   err_exp;

    task automatic do_reset();
        @(negedge clk);
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        s_axis_sop   = 1'b0;
        m_axis_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        err_exp = 1'b0;
    endtask

    // Builds input blocks and the expected framed stream, then drives and scores them.
    task automatic run_stream(input int ready_pct, input int valid_pct, input int par_from,
                              input bit rand_data, input bit full_rate);
        logic [31:0] asmw;
        ibyte_t      ib;
        obyte_t      ob;
        obyte_t      held;
        bit          prev_stall;
        bit          accepted;
        bit          started;
        int          pos;
        int          blk_i;
        int          cyc;
        asmw = ASM;
        exp_q.delete();
        in_q.delete();
        foreach (blk_len[b]) begin
            for (int k = 0; k < 4; k++) begin
                ob.d = 8'(asmw >> (24 - 8 * k));
                ob.sop = (k == 0);
                ob.last = 1'b0;
                ob.par = 1'b0;
                exp_q.push_back(ob);
            end
            for (int i = 0; i < blk_len[b]; i++) begin
                ib.d     = rand_data ? 8'($urandom) : 8'(i % 256);
                ib.first = (i == 0);
                ib.last  = (i == blk_len[b] - 1);
                ib.par   = (i >= par_from);
                in_q.push_back(ib);
                ob.d = ib.d;
                ob.sop = 1'b0;
                ob.last = ib.last;
                ob.par = ib.par;
                exp_q.push_back(ob);
            end
        end
        prev_stall = 0;
        accepted   = 0;
        started    = 0;
        pos        = 0;
        blk_i      = 0;
        cyc        = 0;
        held       = '0;
        while (exp_q.size() != 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (prev_stall)
                check("stall_hold", {m_axis_valid, m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity},
                      {1'b1, held});
            if (full_rate && started)
                check("no_bubble", m_axis_valid, 1'b1);
            check("len_err_track", len_err, err_exp);
            if (accepted) begin
                pos++;
                s_axis_valid = 1'b0;
                accepted = 0;
            end
            m_axis_ready = ($urandom_range(99) < ready_pct);
            if (!s_axis_valid && pos < in_q.size() && $urandom_range(99) < valid_pct) begin
                s_axis_valid     = 1'b1;
                s_axis_data      = in_q[pos].d;
                s_axis_sop       = in_q[pos].first;
                s_axis_last      = in_q[pos].last;
                s_axis_is_parity = in_q[pos].par;
            end
            #1;
            if (m_axis_valid && m_axis_ready) begin
                check("out_byte", {m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity}, exp_q[0]);
                void'(exp_q.pop_front());
                started = 1;
            end
            if (s_axis_valid && s_axis_ready) begin
                accepted = 1;
`ifdef ASM_LEN_CHECK_EN
                if (in_q[pos].last != (blk_i == BLOCK - 1)) err_exp = 1'b1;
`endif
                blk_i = in_q[pos].last ? 0 : blk_i + 1;
            end
            prev_stall = m_axis_valid && !m_axis_ready;
            held = {m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity};
        end
        check("stream_complete", exp_q.size(), 0);
        @(negedge clk);
        if (accepted) pos++;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;
        check("inputs_consumed", pos, in_q.size());
        repeat (3) @(negedge clk);
        check("idle_no_marker", m_axis_valid, 1'b0);
        check("len_err_sticky", len_err, err_exp);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{1, 8'hAA, 0, 0, 1,  0, 1, 8'h1A, 1, 0, 0};
        vecs[2]  = '{1, 8'hAA, 0, 0, 1,  0, 1, 8'hCF, 0, 0, 0};
        vecs[3]  = '{1, 8'hAA, 0, 0, 1,  0, 1, 8'hFC, 0, 0, 0};
        vecs[4]  = '{1, 8'hAA, 0, 0, 1,  0, 1, 8'h1D, 0, 0, 0};
        vecs[5]  = '{1, 8'hAA, 0, 0, 0,  0, 1, 8'h1D, 0, 0, 0};
        vecs[6]  = '{1, 8'hAA, 0, 1, 1,  1, 1, 8'hAA, 0, 0, 1};
        vecs[7]  = '{0, 8'h00, 0, 0, 1,  1, 0, 8'hAA, 0, 0, 1};
        vecs[8]  = '{1, 8'hBB, 1, 0, 1,  1, 1, 8'hBB, 0, 1, 0};
        vecs[9]  = '{1, 8'hCC, 0, 1, 1,  0, 1, 8'h1A, 1, 0, 0};
        vecs[10] = '{0, 8'h00, 0, 0, 0,  0, 1, 8'h1A, 1, 0, 0};
        vecs[11] = '{0, 8'h00, 0, 0, 1,  0, 1, 8'hCF, 0, 0, 0};
        vecs[12] = '{0, 8'h00, 0, 0, 1,  0, 1, 8'hFC, 0, 0, 0};
        vecs[13] = '{0, 8'h00, 0, 0, 1,  0, 1, 8'h1D, 0, 0, 0};
        vecs[14] = '{0, 8'h00, 0, 0, 1,  1, 0, 8'h1D, 0, 0, 0};

        err_exp = 1'b0;
        do_reset();
        check("rst_valid", m_axis_valid, 1'b0);
        check("rst_data", m_axis_data, 8'h00);
        check("rst_sop", m_axis_sop, 1'b0);
        check("rst_last", m_axis_last, 1'b0);
        check("rst_par", m_axis_is_parity, 1'b0);
        check("rst_len_err", len_err, 1'b0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            s_axis_valid     = vecs[i].sv;
            s_axis_data      = vecs[i].sd;
            s_axis_last      = vecs[i].sl;
            s_axis_is_parity = vecs[i].sp;
            m_axis_ready     = vecs[i].mr;
            #1;
            check("vec_s_ready", s_axis_ready, vecs[i].e_sr);
            @(posedge clk);
            #1;
            check("vec_m_valid", m_axis_valid, vecs[i].e_mv);
            check("vec_m_data", m_axis_data, vecs[i].e_md);
            check("vec_m_sop", m_axis_sop, vecs[i].e_sop);
            check("vec_m_last", m_axis_last, vecs[i].e_last);
            check("vec_m_par", m_axis_is_parity, vecs[i].e_par);
        end

        // Single block, counting pattern, no stalls.
        do_reset();
        blk_len = '{512};
        run_stream(100, 100, 512, 1'b0, 1'b1);

        // Back-to-back blocks with parity tail from byte 223.
        do_reset();
        blk_len = '{512, 512};
        run_stream(100, 100, 223, 1'b0, 1'b1);

        // Random backpressure and source gaps over three blocks.
        do_reset();
        blk_len = '{512, 512, 512};
        run_stream(50, 80, 223, 1'b1, 1'b0);

        // Reset in the middle of the marker.
        do_reset();
        @(negedge clk);
        s_axis_valid = 1'b1;
        s_axis_data  = 8'h55;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_asm", m_axis_data, 8'hCF);
        rst_n = 1'b0;
        #1;
        check("rst_asm_valid", m_axis_valid, 1'b0);
        check("rst_asm_data", m_axis_data, 8'h00);
        check("rst_asm_sop", m_axis_sop, 1'b0);
        do_reset();
        blk_len = '{40};
        run_stream(100, 100, 20, 1'b1, 1'b1);

        // Reset after 100 payload bytes.
        @(negedge clk);
        s_axis_valid = 1'b1;
        s_axis_data  = 8'h77;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;
        repeat (104) @(posedge clk);
        #2;
        check("pre_rst_pay_valid", m_axis_valid, 1'b1);
        check("pre_rst_pay_data", m_axis_data, 8'h77);
        rst_n = 1'b0;
        #1;
        check("rst_pay_valid", m_axis_valid, 1'b0);
        check("rst_pay_data", m_axis_data, 8'h00);
        check("rst_pay_last", m_axis_last, 1'b0);
        do_reset();
        blk_len = '{40};
        run_stream(100, 100, 0, 1'b1, 1'b1);

        // Short block followed by a correct one; len_err tracked by the model.
        do_reset();
        blk_len = '{300, 512};
        run_stream(100, 100, 512, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
